mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single memory controller / RAM path between two requesters: port 0 (CPU control unit) and port 1 (secondary master, e.g. DMA or debug loader). Round-robin arbitration grants one complete transaction at a time and forwards it to the controller's valid/RW/address/data interface. Completion is returned to the winning port as a one-cycle ready pulse. A watchdog aborts transactions the controller never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in BUSY waiting for mem_ready before abort (≥1)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  transaction request; held until that port's ready pulse
- req0_rw / req1_rw  in  1  1 = read, 0 = write
- req0_addr / req1_addr  in  ADDR_W  address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_rdata / req1_rdata  out  DATA_W  registered read data
- req0_ready / req1_ready  out  1  one-cycle completion pulse
- mem_valid  out  1  request to memory controller
- mem_rw  out  1  registered copy of granted rw
- mem_addr  out  ADDR_W  registered copy of granted addr
- mem_wdata  out  DATA_W  registered copy of granted wdata
- mem_rdata  in  DATA_W  read data from controller, valid with mem_ready
- mem_ready  in  1  controller acknowledge
- grant  out  2  one-hot owner: 01 = port 0, 10 = port 1, 00 = none
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, BUSY0, BUSY1, DONE.
- IDLE: if any reqN_valid, pick winner; latch rw/addr/wdata into mem_* regs, mem_valid←1, grant←winner, counter←0, go to BUSYN. Otherwise stay.
- Arbitration: only one valid → that port. Both → port not granted last (last_grant reg). last_grant updated on entry to BUSYN.
- BUSYN: mem_valid, mem_rw, mem_addr, mem_wdata held constant; requester inputs ignored. Counter increments each cycle.
  - mem_ready=1: mem_valid←0; if read, reqN_rdata←mem_rdata (writes leave reqN_rdata unchanged); reqN_ready←1; go to DONE.
  - counter reaches TIMEOUT with mem_ready=0: mem_valid←0; reqN_rdata←all ones (read only); reqN_ready←1; timeout_err←1; go to DONE.
  - mem_ready sampled in the same cycle counter hits TIMEOUT: normal completion wins, no timeout_err.
- DONE: reqN_ready←0, timeout_err←0, grant←00, go to IDLE. No arbitration in DONE (gives requester one edge to drop valid).
- Counter width: clog2(TIMEOUT+1); saturates, never wraps.
- mem_ready while IDLE or DONE: ignored.

## Timing
- Reset (reset=0, asynchronous): state IDLE; mem_valid, all reqN_ready, timeout_err, grant = 0; mem_rw, mem_addr, mem_wdata, reqN_rdata = 0; counter = 0; last_grant = port 1 (port 0 wins first tie). Mid-transaction reset drops mem_valid immediately; the interrupted transaction is lost, no ready pulse.
- Request latency: valid sampled at edge E in IDLE → mem_valid high after E.
- Completion: mem_ready sampled at edge F → reqN_ready high for cycle F..F+1 only, mem_valid low after F.
- Requester must deassert valid (or present next request) by edge F+1; IDLE re-arbitrates at F+2.
- Minimum transaction: 1 cycle BUSY (mem_ready at first edge) + DONE + IDLE = new grant every 3 cycles.
- Back-to-back with both ports requesting: grants strictly alternate 0,1,0,1.

## Test plan
- Single read port 0: req0 read addr 0x10, controller returns 0xDEADBEEF after 3 cycles → mem_valid high 3 cycles, mem_addr=0x10, req0_ready one pulse, req0_rdata=0xDEADBEEF, grant=01 then 00.
- Write port 1: req1 write addr 0x20 data 0x12345678 → mem_rw=0, mem_wdata=0x12345678, req1_ready pulse, req1_rdata unchanged.
- Tie and fairness: both valid continuously, 1-cycle ready → grants 01,10,01,10; first grant after reset is port 0; each port ready every 6 cycles.
- Hold stability: during BUSY0 change req0_addr and raise req1_valid → mem_addr unchanged, no grant switch until DONE.
- Timeout: TIMEOUT=4, mem_ready never asserted on a read → after 4 BUSY cycles timeout_err and req0_ready pulse together, req0_rdata=0xFFFFFFFF; with mem_ready on cycle 4 → normal completion, no timeout_err.
- Async reset mid-BUSY1: assert reset=0 between edges → mem_valid, grant, req1_ready drop immediately; after release, pending req0 and req1 both valid → port 0 granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the memory-controller
// side and the status outputs of mem_arbiter.
//   slave  modport: the arbiter (consumes requests and controller replies,
//                   drives grants, completions and the controller request).
//   master modport: the environment (requesters plus memory controller).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_rw;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_rw;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_ready;

  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [1:0]        grant;
  logic              timeout_err;

  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata,
    input  req1_valid, req1_rw, req1_addr, req1_wdata,
    input  mem_rdata, mem_ready,
    output req0_rdata, req0_ready, req1_rdata, req1_ready,
    output mem_valid, mem_rw, mem_addr, mem_wdata,
    output grant, timeout_err
  );

  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata,
    output req1_valid, req1_rw, req1_addr, req1_wdata,
    output mem_rdata, mem_ready,
    input  req0_rdata, req0_ready, req1_rdata, req1_ready,
    input  mem_valid, mem_rw, mem_addr, mem_wdata,
    input  grant, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory controller between
// port 0 (CPU) and port 1 (DMA / debug loader). One whole transaction is
// granted at a time; completion is a one-cycle ready pulse to the winner.
// A watchdog aborts a transaction after TIMEOUT unacknowledged BUSY cycles.
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous active-low reset
//   bus    - mem_arbiter_if.slave: requester ports, controller port, status
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requests
// BUSY0 | port 0 transaction presented to the controller
// BUSY1 | port 1 transaction presented to the controller
// DONE  | ready pulse visible; one edge for the requester to drop valid
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // Expiry is judged on the pre-increment value, so the abort happens on
  // the TIMEOUT-th BUSY edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} state_t;

  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ready0_q, ready0_d;
  logic              ready1_q, ready1_d;
  logic              terr_q, terr_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;    // 1 = port 1 was granted last

  logic              pick1;
  logic              expire;
  logic [DATA_W-1:0] rd_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      terr_q      <= 1'b0;
      grant_q     <= 2'b00;
      cnt_q       <= '0;
      last_q      <= 1'b1;   // port 0 wins the first tie
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      terr_q      <= terr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    terr_d      = 1'b0;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pick1       = 1'b0;
    expire      = (cnt_q == CNT_LAST);
    rd_val      = bus.mem_ready ? bus.mem_rdata : '1;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // Port 1 wins when alone, or on a tie when port 0 went last.
          pick1       = bus.req1_valid && (!bus.req0_valid || !last_q);
          mem_valid_d = 1'b1;
          mem_rw_d    = pick1 ? bus.req1_rw    : bus.req0_rw;
          mem_addr_d  = pick1 ? bus.req1_addr  : bus.req0_addr;
          mem_wdata_d = pick1 ? bus.req1_wdata : bus.req0_wdata;
          grant_d     = pick1 ? 2'b10 : 2'b01;
          last_d      = pick1;
          cnt_d       = '0;
          state_d     = pick1 ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        // A late acknowledge on the expiry edge still counts as success.
        if (bus.mem_ready || expire) begin
          mem_valid_d = 1'b0;
          terr_d      = !bus.mem_ready;
          state_d     = DONE;
          if (state_q == BUSY1) begin
            ready1_d = 1'b1;
            if (mem_rw_q) rdata1_d = rd_val;
          end else begin
            ready0_d = 1'b1;
            if (mem_rw_q) rdata0_d = rd_val;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
  assign bus.req0_ready  = ready0_q;
  assign bus.req1_ready  = ready1_q;
  assign bus.timeout_err = terr_q;
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observations of one granted transaction.
  logic [1:0]  o_g;
  logic [31:0] o_a, o_wd, o_rd0, o_rd1;
  logic        o_rw, o_r0, o_r1, o_te, o_stable;
  int          o_vcyc, o_rcyc;

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_rw = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_rw = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    bus.mem_ready  = 0; bus.mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    clear_inputs();
    @(negedge clk);
    reset = 1;
  endtask

  // Called at a negedge with requests driven. Acts as the controller,
  // acknowledging on the lat-th cycle mem_valid is seen (lat=0: never).
  // Returns at the negedge after the completion edge.
  task automatic serve(input int lat, input logic [31:0] rd);
    bit done = 0;
    @(negedge clk);
    o_g = bus.grant; o_a = bus.mem_addr; o_rw = bus.mem_rw; o_wd = bus.mem_wdata;
    o_vcyc = 0; o_stable = 1;
    o_r0 = 0; o_r1 = 0; o_te = 0; o_rcyc = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.mem_valid) o_vcyc++;
      if (bus.grant !== o_g || bus.mem_addr !== o_a || bus.mem_wdata !== o_wd) o_stable = 0;
      bus.mem_ready = (lat != 0) && (o_vcyc == lat);
      bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_ready = 0;
      bus.mem_rdata = $urandom;
      o_r0 = bus.req0_ready; o_r1 = bus.req1_ready; o_te = bus.timeout_err;
      o_rd0 = bus.req0_rdata; o_rd1 = bus.req1_rdata; o_rcyc = cyc;
      if (o_r0 || o_r1) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL serve_bound: no ready pulse within 20 cycles (grant=%b)", o_g);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    #12;
    checks++;
    if ({bus.mem_valid, bus.req0_ready, bus.req1_ready, bus.timeout_err, bus.grant} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.mem_valid, bus.req0_ready, bus.req1_ready, bus.timeout_err, bus.grant});
    end
    checks++;
    if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.req0_rdata, bus.req1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h want 0",
               bus.mem_addr, bus.mem_wdata, bus.req0_rdata, bus.req1_rdata);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_single_read();
    bus.req0_valid = 1; bus.req0_rw = 1; bus.req0_addr = 32'h10; bus.req0_wdata = 32'h0;
    serve(3, 32'hDEADBEEF);
    bus.req0_valid = 0;
    checks++;
    if (o_g !== 2'b01 || o_a !== 32'h10 || o_rw !== 1'b1) begin
      errors++;
      $display("FAIL rd_issue: grant=%b addr=%h rw=%b want 01/10/1", o_g, o_a, o_rw);
    end
    checks++;
    if (o_vcyc !== 3) begin
      errors++;
      $display("FAIL rd_valid_cycles: got %0d want 3", o_vcyc);
    end
    checks++;
    if (o_r0 !== 1 || o_r1 !== 0 || o_te !== 0 || o_rd0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_done: r0=%b r1=%b te=%b rd0=%h want 1/0/0/deadbeef", o_r0, o_r1, o_te, o_rd0);
    end
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'b00 || bus.req0_ready !== 0 || bus.mem_valid !== 0) begin
      errors++;
      $display("FAIL rd_after: grant=%b ready0=%b valid=%b want 00/0/0", bus.grant, bus.req0_ready, bus.mem_valid);
    end
  endtask

  task automatic test_write_p1();
    bus.req1_valid = 1; bus.req1_rw = 0; bus.req1_addr = 32'h20; bus.req1_wdata = 32'h12345678;
    serve(2, 32'hCAFEF00D);
    bus.req1_valid = 0;
    checks++;
    if (o_g !== 2'b10 || o_a !== 32'h20 || o_rw !== 1'b0 || o_wd !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_issue: grant=%b addr=%h rw=%b wdata=%h want 10/20/0/12345678", o_g, o_a, o_rw, o_wd);
    end
    checks++;
    if (o_r1 !== 1 || o_r0 !== 0 || o_rd1 !== 32'h0 || o_rd0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_done: r1=%b r0=%b rd1=%h rd0=%h want 1/0/0/deadbeef", o_r1, o_r0, o_rd1, o_rd0);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    bus.req0_valid = 1; bus.req0_rw = 1; bus.req0_addr = 32'h30;
    @(negedge clk);
    bus.req0_addr = 32'h44;
    bus.req1_valid = 1; bus.req1_rw = 1; bus.req1_addr = 32'h88;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 32'h30 || bus.grant !== 2'b01 || bus.mem_valid !== 1) begin
        errors++;
        $display("FAIL hold_stable: addr=%h grant=%b valid=%b want 30/01/1", bus.mem_addr, bus.grant, bus.mem_valid);
      end
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'h0BADC0DE;
    @(negedge clk);
    bus.mem_ready = 0;
    bus.req0_valid = 0;
    checks++;
    if (bus.req0_ready !== 1 || bus.req1_ready !== 0 || bus.req0_rdata !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL hold_done: r0=%b r1=%b rd0=%h want 1/0/0badc0de", bus.req0_ready, bus.req1_ready, bus.req0_rdata);
    end
    @(negedge clk);
    // Pending port 1 now gets the bus with its own address.
    serve(1, 32'h77);
    bus.req1_valid = 0;
    checks++;
    if (o_g !== 2'b10 || o_a !== 32'h88 || o_rd1 !== 32'h77) begin
      errors++;
      $display("FAIL hold_next: grant=%b addr=%h rd1=%h want 10/88/77", o_g, o_a, o_rd1);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.req0_valid = 1; bus.req0_rw = 1; bus.req0_addr = 32'h50;
    serve(0, 32'h0);
    bus.req0_valid = 0;
    checks++;
    if (o_vcyc !== TMO || o_te !== 1 || o_r0 !== 1 || o_rd0 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL tmo_abort: busy=%0d te=%b r0=%b rd0=%h want %0d/1/1/ffffffff", o_vcyc, o_te, o_r0, o_rd0, TMO);
    end
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 0 || bus.req0_ready !== 0) begin
      errors++;
      $display("FAIL tmo_pulse: te=%b r0=%b want 0/0", bus.timeout_err, bus.req0_ready);
    end
    bus.req0_valid = 1;
    serve(TMO, 32'h5A5A5A5A);
    bus.req0_valid = 0;
    checks++;
    if (o_vcyc !== TMO || o_te !== 0 || o_r0 !== 1 || o_rd0 !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL tmo_late_ack: busy=%0d te=%b r0=%b rd0=%h want %0d/0/1/5a5a5a5a", o_vcyc, o_te, o_r0, o_rd0, TMO);
    end
    @(negedge clk);
    // A timed-out write must leave rdata alone.
    bus.req0_valid = 1; bus.req0_rw = 0;
    serve(0, 32'h0);
    bus.req0_valid = 0;
    checks++;
    if (o_te !== 1 || o_rd0 !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL tmo_write: te=%b rd0=%h want 1/5a5a5a5a", o_te, o_rd0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int last_rc[2];
    do_reset();
    bus.req0_valid = 1; bus.req0_rw = 0; bus.req0_addr = 32'hA0;
    bus.req1_valid = 1; bus.req1_rw = 0; bus.req1_addr = 32'hB0;
    last_rc[0] = -1; last_rc[1] = -1;
    for (int k = 0; k < 6; k++) begin
      int p;
      p = k % 2;
      serve(1, 32'h0);
      checks++;
      if (o_g !== (p == 0 ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got %b want %b", k, o_g, (p == 0 ? 2'b01 : 2'b10));
      end
      if (last_rc[p] >= 0) begin
        checks++;
        if (o_rcyc - last_rc[p] != 6) begin
          errors++;
          $display("FAIL b2b_period[%0d]: got %0d want 6", k, o_rcyc - last_rc[p]);
        end
      end
      last_rc[p] = o_rcyc;
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req1_valid = 1; bus.req1_rw = 1; bus.req1_addr = 32'hC0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'b10 || bus.mem_valid !== 1) begin
      errors++;
      $display("FAIL arst_pre: grant=%b valid=%b want 10/1", bus.grant, bus.mem_valid);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (bus.mem_valid !== 0 || bus.grant !== 2'b00 || bus.req1_ready !== 0) begin
      errors++;
      $display("FAIL arst_drop: valid=%b grant=%b r1=%b want 0/00/0", bus.mem_valid, bus.grant, bus.req1_ready);
    end
    bus.req0_valid = 1; bus.req0_rw = 1; bus.req0_addr = 32'hD0;
    @(negedge clk);
    reset = 1;
    serve(1, 32'h1111);
    bus.req0_valid = 0;
    checks++;
    if (o_g !== 2'b01 || o_a !== 32'hD0 || o_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL arst_first: grant=%b addr=%h rd1=%h want 01/d0/0", o_g, o_a, o_rd1);
    end
    @(negedge clk);
    serve(1, 32'h2222);
    bus.req1_valid = 0;
    @(negedge clk);
  endtask

  // Transaction-level model: pending requests per port, alternate on ties,
  // expected read data per port, expected BUSY length min(lat, TMO).
  task automatic test_random();
    logic        pv[2], prw[2];
    logic [31:0] pa[2], pw[2], exp_rd[2];
    int          last_p, win, lat, busy;
    logic [31:0] rd;
    logic        tmo;
    do_reset();
    last_p = 1;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; prw[p] = 0; pa[p] = 0; pw[p] = 0; exp_rd[p] = 0;
    end
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p] && $urandom_range(0, 9) < 6) begin
          pv[p] = 1; prw[p] = 1'($urandom_range(0, 1)); pa[p] = $urandom; pw[p] = $urandom;
        end
      if (!pv[0] && !pv[1]) begin
        int p = $urandom_range(0, 1);
        pv[p] = 1; prw[p] = 1; pa[p] = $urandom; pw[p] = $urandom;
      end
      bus.req0_valid = pv[0]; bus.req0_rw = prw[0]; bus.req0_addr = pa[0]; bus.req0_wdata = pw[0];
      bus.req1_valid = pv[1]; bus.req1_rw = prw[1]; bus.req1_addr = pa[1]; bus.req1_wdata = pw[1];
      win = (pv[0] && pv[1]) ? 1 - last_p : (pv[1] ? 1 : 0);
      last_p = win;
      lat = $urandom_range(1, 6);
      rd = $urandom;
      tmo = lat > TMO;
      busy = tmo ? TMO : lat;
      if (prw[win]) exp_rd[win] = tmo ? 32'hFFFFFFFF : rd;
      serve(tmo ? 0 : lat, rd);
      checks++;
      if (o_g !== (win == 1 ? 2'b10 : 2'b01) || o_a !== pa[win] || o_rw !== prw[win] ||
          o_wd !== pw[win] || o_stable !== 1) begin
        errors++;
        $display("FAIL rnd_issue[%0d]: grant=%b addr=%h rw=%b wd=%h stable=%b want port %0d addr=%h rw=%b wd=%h",
                 n, o_g, o_a, o_rw, o_wd, o_stable, win, pa[win], prw[win], pw[win]);
      end
      checks++;
      if (o_vcyc !== busy || o_te !== tmo || o_r0 !== (win == 0) || o_r1 !== (win == 1)) begin
        errors++;
        $display("FAIL rnd_done[%0d]: busy=%0d te=%b r0=%b r1=%b want %0d/%b port %0d",
                 n, o_vcyc, o_te, o_r0, o_r1, busy, tmo, win);
      end
      checks++;
      if (o_rd0 !== exp_rd[0] || o_rd1 !== exp_rd[1]) begin
        errors++;
        $display("FAIL rnd_rdata[%0d]: rd0=%h rd1=%h want %h %h", n, o_rd0, o_rd1, exp_rd[0], exp_rd[1]);
      end
      pv[win] = 0;
      if (win == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
      @(negedge clk);
      checks++;
      if (bus.grant !== 2'b00 || bus.req0_ready !== 0 || bus.req1_ready !== 0) begin
        errors++;
        $display("FAIL rnd_done_state[%0d]: grant=%b r0=%b r1=%b want 00/0/0",
                 n, bus.grant, bus.req0_ready, bus.req1_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_p1();
    test_hold();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
